oam_dma_arbiter: RTL



---
 rtl/oam_dma_arbiter_pkg.sv | 23 ++
 rtl/oam_dma_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter_pkg
// Shared enums and constants for the CPU-side bus logic.
//
// Contents:
//   dma_state_e             sprite DMA sequencer states
//   DEFAULT_DMA_REG_ADDR    CPU write address that starts a sprite DMA
//   DEFAULT_OAM_DATA_ADDR   destination address of every DMA write
// ---------------------------------------------------------------------------
package oam_dma_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] DEFAULT_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] DEFAULT_OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// ---------------------------------------------------------------------------
// oam_dma_arbiter
// Sits between the CPU core and the system bus. While idle, CPU traffic is
// passed straight through. A CPU write of page XX to DMA_REG_ADDR stalls the
// CPU and copies $XX00-$XXFF to OAM_DATA_ADDR, one read/write pair per byte,
// then hands the bus back.
//
// Optional feature macro: OAM_DMA_ALIGN_EN
//   defined   : a phase flop toggles every clock; an extra ALIGN cycle is
//               inserted after HALT when needed so every READ lands on
//               phase 0 (stall 513 or 514 cycles).
//   undefined : no phase flop, no ALIGN cycle (stall always 513 cycles).
//
// Ports:
//   clk        system clock, one CPU cycle per edge
//   rst        asynchronous active-low reset
//   cpu_addr   CPU address            cpu_read / cpu_write  CPU strobes
//   cpu_wdata  CPU write data         cpu_rdata  read data back to CPU
//   cpu_stall  freezes the CPU while any DMA state is active
//   bus_addr / bus_read / bus_write / bus_wdata  system bus request
//   bus_rdata  system bus read data
//   dma_busy   same as cpu_stall
//   dma_done   one-cycle registered pulse after the final OAM write
// ---------------------------------------------------------------------------
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DEFAULT_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = DEFAULT_OAM_DATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic [15:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_busy,
  output logic        dma_done
);

  dma_state_e state;
  dma_state_e state_next;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_buf;
  logic       trigger;
  logic       last_byte;

  // Only a write in IDLE starts a transfer; while stalled the CPU strobes
  // are ignored, so a transfer can never restart itself.
  assign trigger   = (state == IDLE) && cpu_write && (cpu_addr == DMA_REG_ADDR);
  assign last_byte = (idx == 8'hFF);

`ifdef OAM_DMA_ALIGN_EN
  logic phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
    end else begin
      phase <= ~phase;
    end
  end
`endif

  // State register plus the page/index/data registers and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      page     <= 8'h00;
      idx      <= 8'h00;
      data_buf <= 8'h00;
      dma_done <= 1'b0;
    end else begin
      state    <= state_next;
      dma_done <= (state == WRITE) && last_byte;
      case (state)
        IDLE: begin
          if (trigger) begin
            page <= cpu_wdata;
            idx  <= 8'h00;
          end
        end
        READ:    data_buf <= bus_rdata;
        // idx wraps within the page; there is deliberately no carry into page.
        WRITE:   idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

  // Next-state and bus outputs. In DMA states the strobes depend only on
  // the registered state, so they cannot glitch.
  always_comb begin
    state_next = state;
    bus_addr   = cpu_addr;
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    bus_wdata  = cpu_wdata;
    case (state)
      IDLE: begin
        bus_read  = cpu_read;
        bus_write = cpu_write;
        if (trigger) begin
          state_next = HALT;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        // HALT on phase 0 needs one extra cycle so READ lands on phase 0.
        state_next = (phase == 1'b0) ? ALIGN : READ;
`else
        state_next = READ;
`endif
      end
      ALIGN: begin
        state_next = READ;
      end
      READ: begin
        bus_addr   = {page, idx};
        bus_read   = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_write  = 1'b1;
        bus_wdata  = data_buf;
        state_next = last_byte ? IDLE : READ;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cpu_rdata = bus_rdata;
  assign cpu_stall = (state != IDLE);
  assign dma_busy  = cpu_stall;

endmodule
